// File: rtl/r4_butterfly_pipe.sv
// Radix-4 DIT butterfly, two register stages with valid/ready flow control.
// S1 forms the pairwise sums/differences a,b,c,d. S2 forms X0..X3, applies
// the inverse swap and the per-beat arithmetic right shift, and drives the
// outputs. beat_cnt counts output beats consumed downstream.
module r4_butterfly_pipe #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] xr0,
  input  logic signed [W-1:0] xr1,
  input  logic signed [W-1:0] xr2,
  input  logic signed [W-1:0] xr3,
  input  logic signed [W-1:0] xi0,
  input  logic signed [W-1:0] xi1,
  input  logic signed [W-1:0] xi2,
  input  logic signed [W-1:0] xi3,
  input  logic                inv,
  input  logic [1:0]          scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+1:0] yr0,
  output logic signed [W+1:0] yr1,
  output logic signed [W+1:0] yr2,
  output logic signed [W+1:0] yr3,
  output logic signed [W+1:0] yi0,
  output logic signed [W+1:0] yi1,
  output logic signed [W+1:0] yi2,
  output logic signed [W+1:0] yi3,
  output logic [CW-1:0]       beat_cnt
);

  localparam int AW = W + 1;
  localparam int OW = W + 2;

  function automatic logic signed [AW-1:0] sx1(input logic signed [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic signed [OW-1:0] sx2(input logic signed [AW-1:0] v);
    return {v[AW-1], v};
  endfunction

  logic s1_valid, s2_valid;
  logic s1_en, s2_en;

  logic                 s1_inv;
  logic [1:0]           s1_scale;
  logic signed [AW-1:0] a_r, a_i, b_r, b_i, c_r, c_i, d_r, d_i;

  // A stage may load when it is empty or when its content moves on this cycle.
  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en && RST;
  assign out_valid = s2_valid;

  // S1: capture control and form the first-level sums and differences.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RST) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_scale <= 2'd0;
      a_r      <= '0;
      a_i      <= '0;
      b_r      <= '0;
      b_i      <= '0;
      c_r      <= '0;
      c_i      <= '0;
      d_r      <= '0;
      d_i      <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_inv   <= inv;
      s1_scale <= scale;
      a_r      <= sx1(xr0) + sx1(xr2);
      a_i      <= sx1(xi0) + sx1(xi2);
      b_r      <= sx1(xr0) - sx1(xr2);
      b_i      <= sx1(xi0) - sx1(xi2);
      c_r      <= sx1(xr1) + sx1(xr3);
      c_i      <= sx1(xi1) + sx1(xi3);
      d_r      <= sx1(xr1) - sx1(xr3);
      d_i      <= sx1(xi1) - sx1(xi3);
    end
  end

  logic [1:0]           shamt;
  logic signed [OW-1:0] p_r, p_i, q_r, q_i;
  logic signed [OW-1:0] n_yr0, n_yr1, n_yr2, n_yr3;
  logic signed [OW-1:0] n_yi0, n_yi1, n_yi2, n_yi3;

  // S2 datapath: second-level sums, scaling shift and forward/inverse swap.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    shamt = s1_scale[1] ? 2'd2 : s1_scale;
    p_r   = (sx2(b_r) + sx2(d_i)) >>> shamt;
    p_i   = (sx2(b_i) - sx2(d_r)) >>> shamt;
    q_r   = (sx2(b_r) - sx2(d_i)) >>> shamt;
    q_i   = (sx2(b_i) + sx2(d_r)) >>> shamt;
    n_yr0 = (sx2(a_r) + sx2(c_r)) >>> shamt;
    n_yi0 = (sx2(a_i) + sx2(c_i)) >>> shamt;
    n_yr2 = (sx2(a_r) - sx2(c_r)) >>> shamt;
    n_yi2 = (sx2(a_i) - sx2(c_i)) >>> shamt;
    n_yr1 = p_r;
    n_yi1 = p_i;
    n_yr3 = q_r;
    n_yi3 = q_i;
    if (s1_inv) begin
      n_yr1 = q_r;
      n_yi1 = q_i;
      n_yr3 = p_r;
      n_yi3 = p_i;
    end
  end

  // S2: output register, held while the downstream stalls.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s2_valid <= 1'b0;
      yr0      <= '0;
      yr1      <= '0;
      yr2      <= '0;
      yr3      <= '0;
      yi0      <= '0;
      yi1      <= '0;
      yi2      <= '0;
      yi3      <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      yr0      <= n_yr0;
      yr1      <= n_yr1;
      yr2      <= n_yr2;
      yr3      <= n_yr3;
      yi0      <= n_yi0;
      yi1      <= n_yi1;
      yi2      <= n_yi2;
      yi3      <= n_yi3;
    end
  end

  // Count consumed output beats, wrapping naturally at 2^CW.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_r4_butterfly_pipe.sv
// Scoreboard bench for r4_butterfly_pipe (W=8, CW=4). The driver pushes the
// expected output of each accepted beat; the monitor pops and compares on
// every consumed output beat and checks that stalled outputs hold.
module tb_r4_butterfly_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  typedef logic [7:0][W+1:0] exp_t;  // [0..3] = real X0..X3, [4..7] = imag

  typedef struct packed {
    logic signed [W-1:0] r0, r1, r2, r3;
    logic signed [W-1:0] i0, i1, i2, i3;
    logic                iv;
    logic [1:0]          sc;
  } beat_t;

  logic                CLK, RST;
  logic                in_valid, in_ready, inv, out_valid, out_ready;
  logic [1:0]          scale;
  logic signed [W-1:0] xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3;
  logic signed [W+1:0] yr0, yr1, yr2, yr3, yi0, yi1, yi2, yi3;
  logic [CW-1:0]       beat_cnt;
  exp_t                got;

  r4_butterfly_pipe #(.W(W), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
    .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
    .inv(inv), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .yr0(yr0), .yr1(yr1), .yr2(yr2), .yr3(yr3),
    .yi0(yi0), .yi1(yi1), .yi2(yi2), .yi3(yi3),
    .beat_cnt(beat_cnt)
  );

  assign got = {yi3, yi2, yi1, yi0, yr3, yr2, yr1, yr0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  int   n_acc = 0;
  int   cons_cnt = 0;
  exp_t sb[$];
  exp_t snap;
  bit   stall_prev = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: full radix-4 sums, -j twiddle forward, swap of X1/X3 for inverse.
  function automatic exp_t model(input beat_t b);
    int   r0, r1, r2, r3, i0, i1, i2, i3, sh;
    int   yr[4];
    int   yi[4];
    exp_t e;
    r0 = $signed(b.r0); r1 = $signed(b.r1); r2 = $signed(b.r2); r3 = $signed(b.r3);
    i0 = $signed(b.i0); i1 = $signed(b.i1); i2 = $signed(b.i2); i3 = $signed(b.i3);
    yr[0] = r0 + r1 + r2 + r3;  yi[0] = i0 + i1 + i2 + i3;
    yr[2] = r0 - r1 + r2 - r3;  yi[2] = i0 - i1 + i2 - i3;
    yr[1] = r0 + i1 - r2 - i3;  yi[1] = i0 - r1 - i2 + r3;
    yr[3] = r0 - i1 - r2 + i3;  yi[3] = i0 + r1 - i2 - r3;
    if (b.iv) begin
      sh = yr[1]; yr[1] = yr[3]; yr[3] = sh;
      sh = yi[1]; yi[1] = yi[3]; yi[3] = sh;
    end
    sh = (b.sc >= 2'd2) ? 2 : int'(b.sc);
    for (int k = 0; k < 4; k++) begin
      e[k]   = 10'(yr[k] >>> sh);
      e[k+4] = 10'(yi[k] >>> sh);
    end
    return e;
  endfunction

  function automatic beat_t mkb(input int r0, r1, r2, r3, i0, i1, i2, i3,
                                input bit iv, input int sc);
    beat_t b;
    b.r0 = 8'(r0); b.r1 = 8'(r1); b.r2 = 8'(r2); b.r3 = 8'(r3);
    b.i0 = 8'(i0); b.i1 = 8'(i1); b.i2 = 8'(i2); b.i3 = 8'(i3);
    b.iv = iv;
    b.sc = 2'(sc);
    return b;
  endfunction

  // Hand-computed expectation: X0r, X1r, X2r, X3r, X0i, X1i, X2i, X3i.
  function automatic exp_t mke(input int r0, r1, r2, r3, i0, i1, i2, i3);
    exp_t e;
    e[0] = 10'(r0); e[1] = 10'(r1); e[2] = 10'(r2); e[3] = 10'(r3);
    e[4] = 10'(i0); e[5] = 10'(i1); e[6] = 10'(i2); e[7] = 10'(i3);
    return e;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.r0 = 8'($urandom); b.r1 = 8'($urandom); b.r2 = 8'($urandom); b.r3 = 8'($urandom);
    b.i0 = 8'($urandom); b.i1 = 8'($urandom); b.i2 = 8'($urandom); b.i3 = 8'($urandom);
    b.iv = 1'($urandom_range(0, 1));
    b.sc = 2'($urandom_range(0, 3));
    return b;
  endfunction

  // Monitor: compare every consumed beat, check stalled outputs hold.
  always @(negedge CLK) begin
    if (RST !== 1'b1) begin
      sb.delete();
      cons_cnt   = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        checks++;
        if (got !== snap) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h at %0t", got, snap, $time);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none at %0t", got, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          for (int k = 0; k < 8; k++)
            check($sformatf("%s%0d", (k < 4) ? "yr" : "yi", k % 4),
                  $signed(got[k]), $signed(e[k]));
          check("beat_cnt", beat_cnt, cons_cnt & ((1 << CW) - 1));
        end
        cons_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      snap       = got;
    end
  end

  task automatic send(input beat_t b, input exp_t e);
    int guard = 0;
    xr0 = b.r0; xr1 = b.r1; xr2 = b.r2; xr3 = b.r3;
    xi0 = b.i0; xi1 = b.i1; xi2 = b.i2; xi3 = b.i3;
    inv = b.iv; scale = b.sc; in_valid = 1'b1;
    forever begin
      @(negedge CLK);
      if (in_ready) begin
        sb.push_back(e);
        n_acc++;
        @(posedge CLK); #1;
        break;
      end
      guard++;
      if (guard > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck low at %0t", $time);
        in_valid = 1'b0;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && g < 1000) begin
      @(negedge CLK);
      g++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge CLK); #1;
  endtask

  // RST low for exactly one edge; check the state the cycle after.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    RST       = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", in_ready, 0);
    @(posedge CLK); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready_after", in_ready, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_yr0", yr0, 0);
    check("rst_yi3", yi3, 0);
    RST = 1'b1;
  endtask

  // Beat must be in S1 one cycle after acceptance and at the output the next.
  task automatic check_latency(input string tag);
    @(negedge CLK);
    check({tag, "_s1"}, out_valid, 0);
    @(negedge CLK);
    check({tag, "_out"}, out_valid, 1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int  acc0;
    bit  done;
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inv = 1'b0; scale = 2'd0;
    xr0 = '0; xr1 = '0; xr2 = '0; xr3 = '0; xi0 = '0; xi1 = '0; xi2 = '0; xi3 = '0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Directed vectors, first one with a latency check from an empty pipe.
    out_ready = 1'b1;
    send(mkb(10, 20, 30, 40, 0, 0, 0, 0, 0, 0), mke(100, -20, -20, -20, 0, 20, 0, -20));
    idle();
    check_latency("lat_fwd");
    send(mkb(10, 20, 30, 40, 0, 0, 0, 0, 1, 0), mke(100, -20, -20, -20, 0, -20, 0, 20));
    send(mkb(10, 20, 30, 40, 0, 0, 0, 0, 0, 2), mke(25, -5, -5, -5, 0, 5, 0, -5));
    send(mkb(10, 20, 30, 40, 0, 0, 0, 0, 0, 1), mke(50, -10, -10, -10, 0, 10, 0, -10));
    send(mkb(10, 20, 30, 40, 0, 0, 0, 0, 0, 3), mke(25, -5, -5, -5, 0, 5, 0, -5));
    send(mkb(-128, -128, -128, -128, -128, -128, -128, -128, 0, 0),
         mke(-512, 0, 0, 0, -512, 0, 0, 0));
    send(mkb(127, 127, 127, 127, 127, 127, 127, 127, 0, 0), mke(508, 0, 0, 0, 508, 0, 0, 0));
    send(mkb(-1, 0, 0, 0, 0, 0, 0, 0, 0, 1), mke(-1, -1, -1, -1, 0, 0, 0, 0));
    send(mkb(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), mke(1, 0, -1, 0, 0, -1, 0, 1));
    send(mkb(0, 0, 0, 0, 0, 1, 0, 0, 1, 0), mke(0, -1, 0, 1, 1, 0, -1, 0));
    idle();
    drain();
    @(negedge CLK);
    check("cnt_directed", beat_cnt, 10);
    @(posedge CLK); #1;

    // Backpressure: two beats fill the pipe, then in_ready must drop.
    do_reset();
    acc0 = n_acc;
    fork
      begin
        send(mkb(1, 2, 3, 4, 0, 0, 0, 0, 0, 0), mke(10, -2, -2, -2, 0, 2, 0, -2));
        send(mkb(5, 0, 0, 0, 0, 0, 0, 0, 0, 0), mke(5, 5, 5, 5, 0, 0, 0, 0));
        send(mkb(0, 0, 7, 0, 0, 0, 0, 0, 0, 0), mke(7, -7, 7, -7, 0, 0, 0, 0));
        send(mkb(0, 0, 0, 0, 3, 0, 0, 0, 0, 0), mke(0, 0, 0, 0, 3, 3, 3, 3));
        idle();
      end
      begin
        repeat (6) @(negedge CLK);
        check("bp_in_ready", in_ready, 0);
        check("bp_accepted", n_acc - acc0, 2);
        @(posedge CLK); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(negedge CLK);
    check("bp_cnt", beat_cnt, 4);
    @(posedge CLK); #1;

    // Counter wrap: 17 beats on a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      beat_t b;
      b = rand_beat();
      send(b, model(b));
    end
    idle();
    drain();
    @(negedge CLK);
    check("wrap_cnt", beat_cnt, 1);
    @(posedge CLK); #1;

    // Random streaming with independent valid gaps and ready toggling.
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          beat_t b;
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge CLK); #1;
          end
          b = rand_beat();
          send(b, model(b));
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge CLK); #1;
        end
      end
    join
    drain();

    // Reset while both stages hold beats; nothing stale may come out.
    out_ready = 1'b0;
    send(mkb(9, 9, 9, 9, 9, 9, 9, 9, 0, 0), mke(36, 0, 0, 0, 36, 0, 0, 0));
    send(mkb(8, 8, 8, 8, 8, 8, 8, 8, 0, 0), mke(32, 0, 0, 0, 32, 0, 0, 0));
    idle();
    do_reset();
    out_ready = 1'b1;
    send(mkb(10, 20, 30, 40, 0, 0, 0, 0, 0, 0), mke(100, -20, -20, -20, 0, 20, 0, -20));
    idle();
    check_latency("lat_post_rst");
    repeat (4) @(posedge CLK);
    #1;
    check("post_rst_queue", sb.size(), 0);
    @(negedge CLK);
    check("post_rst_cnt", beat_cnt, 1);
    check("post_rst_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
